apb_completer_mem: RTL and testbench

APB completer (slave) that answers transfers issued by the AHB-to-APB bridge on one select line of `Pselx`. It holds a word-addressed register file, inserts a programmable number of wait states, flags out-of-range or misaligned accesses with `Pslverr`, and keeps transfer and error counters. It sits on the APB side of the bridge, one instance per peripheral slot.

---
 rtl/apb_completer_mem.sv | 149 ++++++++++++++
 tb/tb_apb_completer_mem.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_completer_mem.sv
// APB completer with a word-addressed register file, programmable wait states,
// address-window error response and transfer/error counters.
module apb_completer_mem #(
    parameter int          SEL_INDEX   = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr,
    output logic [15:0] Xfer_count,
    output logic [7:0]  Err_count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        wr_q;
    logic        err_q;
    logic [AW-1:0] idx_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [15:0] xfer_q;
    logic [7:0]  errc_q;
    logic [31:0] mem_q [DEPTH];

    logic        sel;
    logic        latch_w;
    logic        complete_w;
    logic [31:0] off_w;
    logic        err_w;
    logic [AW-1:0] idx_w;
    logic [DEPTH-1:0] we_w;
    logic        unused_sel_bits;

    assign sel             = Pselx[SEL_INDEX];
    assign unused_sel_bits = ^Pselx;

    // Decode happens while the setup phase is on the bus, so only the
    // resulting index and error flag need to be held through the access phase.
    assign off_w = Paddr - BASE_ADDR;
    assign err_w = (off_w >= SPAN) | (Paddr[1:0] != 2'b00);
    assign idx_w = off_w[AW+1:2];

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        latch_w    = 1'b0;
        complete_w = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel && !Penable) begin
                    latch_w = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!sel) begin
                    state_d = IDLE;
                end else if (!Penable) begin
                    latch_w = 1'b1;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    complete_w = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (latch_w) begin
            wcnt_d = 4'(WAIT_STATES);
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            xfer_q  <= 16'd0;
            errc_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (latch_w) begin
                wr_q    <= Pwrite;
                err_q   <= err_w;
                idx_q   <= idx_w;
                wdata_q <= Pwdata;
                // Memory cannot change while this transfer is pending, so the
                // read word can be captured at setup.
                rdata_q <= mem_q[idx_w];
            end
            if (complete_w) begin
                if (err_q) begin
                    if (errc_q != 8'hFF) begin
                        errc_q <= errc_q + 8'd1;
                    end
                end else begin
                    xfer_q <= xfer_q + 16'd1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we_w[gi] = complete_w & wr_q & ~err_q & (idx_q == AW'(gi));
        end
    endgenerate

    always_ff @(posedge Hclk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (Hreset) begin
                mem_q[i] <= 32'd0;
            end else if (we_w[i]) begin
                mem_q[i] <= wdata_q;
            end
        end
    end

    assign Pready     = (state_q == ACCESS) && (wcnt_q == 4'd0);
    assign Pslverr    = Pready & err_q;
    assign Prdata     = (Pready && !wr_q && !err_q) ? rdata_q : 32'd0;
    assign Xfer_count = xfer_q;
    assign Err_count  = errc_q;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Randomized bench for apb_completer_mem: two instances on one bus (select
// bits 0 and 1, 0 and 3 wait states) checked against a behavioural model.
module tb_apb_completer_mem;

    logic        Hclk;
    logic        Hreset;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;

    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b;
    logic        pslverr_a, pslverr_b;
    logic [15:0] xfer_a, xfer_b;
    logic [7:0]  errc_a, errc_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] mem_m [2][16];
    logic [15:0] xfer_m [2];
    logic [7:0]  err_m [2];

    apb_completer_mem #(.SEL_INDEX(0), .BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_STATES(0)) u_dut_a (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_a), .Pready(pready_a),
        .Pslverr(pslverr_a), .Xfer_count(xfer_a), .Err_count(errc_a)
    );

    apb_completer_mem #(.SEL_INDEX(1), .BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_STATES(3)) u_dut_b (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_b), .Pready(pready_b),
        .Pslverr(pslverr_b), .Xfer_count(xfer_b), .Err_count(errc_b)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;
    always @(posedge Hclk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_rdata(input int s);
        return (s == 0) ? prdata_a : prdata_b;
    endfunction
    function automatic logic get_ready(input int s);
        return (s == 0) ? pready_a : pready_b;
    endfunction
    function automatic logic get_slverr(input int s);
        return (s == 0) ? pslverr_a : pslverr_b;
    endfunction
    function automatic logic [15:0] get_xfer(input int s);
        return (s == 0) ? xfer_a : xfer_b;
    endfunction
    function automatic logic [7:0] get_errc(input int s);
        return (s == 0) ? errc_a : errc_b;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) mem_m[s][w] = 32'd0;
            xfer_m[s] = 16'd0;
            err_m[s]  = 8'd0;
        end
    endtask

    task automatic idle();
        Pselx   = 3'b000;
        Penable = 1'b0;
        @(posedge Hclk); #1;
    endtask

    // One complete APB transfer; leaves the bus in its completion state so a
    // following call forms a back-to-back transfer.
    task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        int          waits;
        logic [31:0] off;
        bit          err;
        int          idx;
        logic [31:0] exp_rd;
        off    = addr - 32'h8000_0000;
        err    = (off >= 32'd64) || (addr % 4 != 0);
        idx    = err ? 0 : int'(off / 4);
        exp_rd = (err || wr) ? 32'd0 : mem_m[s][idx];

        Pselx   = 3'(1 << s);
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = data;
        @(negedge Hclk);
        check("setup_pready", 32'(get_ready(s)), 32'd0);
        check("setup_prdata", get_rdata(s), 32'd0);
        @(posedge Hclk); #1;
        Penable = 1'b1;
        waits = 0;
        @(negedge Hclk);
        while (get_ready(s) !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge Hclk);
        end
        check("wait_states", 32'(waits), (s == 0) ? 32'd0 : 32'd3);
        check("pslverr", 32'(get_slverr(s)), 32'(err));
        check("prdata", get_rdata(s), exp_rd);
        @(posedge Hclk); #1;
        if (err) begin
            if (err_m[s] != 8'd255) err_m[s] = err_m[s] + 8'd1;
        end else begin
            if (wr) mem_m[s][idx] = data;
            xfer_m[s] = xfer_m[s] + 16'd1;
        end
        check("xfer_count", 32'(get_xfer(s)), 32'(xfer_m[s]));
        check("err_count", 32'(get_errc(s)), 32'(err_m[s]));
        $display("xfer sel=%0d wr=%0b addr=%h wdata=%h exp_rdata=%h err=%0b waits=%0d",
                 s, wr, addr, data, exp_rd, err, waits);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_prdata_a"}, prdata_a, 32'd0);
        check({tag, "_prdata_b"}, prdata_b, 32'd0);
        check({tag, "_pready"}, {30'd0, pready_a, pready_b}, 32'd0);
        check({tag, "_pslverr"}, {30'd0, pslverr_a, pslverr_b}, 32'd0);
        check({tag, "_xfer"}, {xfer_a, xfer_b}, 32'd0);
        check({tag, "_errc"}, {16'd0, errc_a, errc_b}, 32'd0);
    endtask

    initial begin
        int start;
        int s;
        int r;
        bit wr;
        logic [31:0] addr;

        Hreset  = 1'b1;
        Pselx   = 3'b000;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = 32'd0;
        Pwdata  = 32'd0;
        model_reset();
        @(posedge Hclk);
        @(negedge Hclk);
        check_all_zero("reset");
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        idle();

        // Single write then read, no wait states.
        xfer(0, 1'b1, 32'h8000_0000, 32'h1234_ABCD);
        xfer(0, 1'b0, 32'h8000_0000, 32'd0);
        idle();
        check("t1_xfer_count", 32'(xfer_a), 32'd2);

        // Back-to-back burst of four writes and four reads.
        start = cyc;
        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'h8000_0004 + 32'(4 * i), 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'h8000_0004 + 32'(4 * i), 32'd0);
        check("burst_cycles", 32'(cyc - start), 32'd16);
        idle();
        check("burst_xfer_count", 32'(xfer_a), 32'd10);

        // Three wait states: five bus cycles from setup.
        start = cyc;
        xfer(1, 1'b0, 32'h8000_0000, 32'd0);
        check("ws3_cycles", 32'(cyc - start), 32'd5);
        idle();

        // Out-of-range and misaligned writes leave memory untouched.
        xfer(0, 1'b1, 32'h8000_0040, 32'hBAD0_0001);
        xfer(0, 1'b1, 32'h8000_0002, 32'hBAD0_0002);
        xfer(0, 1'b0, 32'h8000_0000, 32'd0);
        idle();
        check("err_write_errc", 32'(errc_a), 32'd2);
        check("err_write_word0", mem_m[0][0], 32'h1234_ABCD);

        // Abort: select drops during the access phase.
        Pselx   = 3'b001;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = 32'h8000_0000;
        Pwdata  = 32'hDEAD_BEEF;
        @(posedge Hclk); #1;
        Pselx   = 3'b000;
        Penable = 1'b1;
        @(posedge Hclk); #1;
        Penable = 1'b0;
        @(negedge Hclk);
        check("abort_pready", 32'(pready_a), 32'd0);
        check("abort_xfer", 32'(xfer_a), 32'(xfer_m[0]));
        check("abort_errc", 32'(errc_a), 32'(err_m[0]));
        @(posedge Hclk); #1;
        xfer(0, 1'b0, 32'h8000_0000, 32'd0);
        idle();

        // Reset in the middle of a wait-stated write.
        xfer(1, 1'b1, 32'h8000_0008, 32'h5555_AAAA);
        Pselx   = 3'b010;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = 32'h8000_000C;
        Pwdata  = 32'h7777_1111;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(posedge Hclk); #1;
        Hreset = 1'b1;
        @(posedge Hclk); #1;
        Hreset  = 1'b0;
        Pselx   = 3'b000;
        Penable = 1'b0;
        @(negedge Hclk);
        check_all_zero("midreset");
        model_reset();
        @(posedge Hclk); #1;
        xfer(1, 1'b0, 32'h8000_0008, 32'd0);
        xfer(1, 1'b0, 32'h8000_000C, 32'd0);
        xfer(0, 1'b0, 32'h8000_0000, 32'd0);
        idle();

        // Randomized traffic across both completers.
        for (int n = 0; n < 80; n++) begin
            s  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            case (r)
                0: addr = 32'h8000_0000 - 32'(4 * $urandom_range(1, 4));
                1: addr = 32'h8000_0040 + 32'(4 * $urandom_range(0, 8));
                2: addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                default: addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15));
            endcase
            xfer(s, wr, addr, $urandom);
            if ($urandom_range(0, 9) < 3) idle();
        end
        idle();

        // Error counter saturation.
        for (int n = 0; n < 260; n++) xfer(0, 1'b0, 32'h8000_0100, 32'd0);
        idle();
        check("errc_saturated", 32'(errc_a), 32'd255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
